matrix_row_feeder: RTL and testbench



---
 rtl/matrix_feeder_pkg.sv | 25 ++
 rtl/row_buffer.sv | 43 ++++
 rtl/matrix_row_feeder.sv | 170 +++++++++++++++++
 tb/tb_matrix_row_feeder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_feeder_pkg
//  Description : Shared state encoding and counter sizing helper for the
//                matrix row feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    CLEAR  = 3'd2,
    STREAM = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5
  } state_e;

  // One extra bit above log2 so a counter can hold N itself without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : row_buffer
//  Description : ENTRIES x ROW_WIDTH register file, one write port, one
//                combinational read port. Pure storage, no control.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_buffer #(
  parameter int ENTRIES   = 4,
  parameter int ROW_WIDTH = 32,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [IDX_WIDTH-1:0] wr_idx_i,
  input  logic [ROW_WIDTH-1:0] wr_data_i,
  input  logic [IDX_WIDTH-1:0] rd_idx_i,
  output logic [ROW_WIDTH-1:0] rd_data_o
);

  logic [ROW_WIDTH-1:0] mem_q [ENTRIES];

  // Write the addressed entry; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (wr_en_i && (wr_idx_i == IDX_WIDTH'(i))) begin
        mem_q[i] <= wr_data_i;
      end
    end
  end

  // Read mux; an out-of-range index returns zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (rd_idx_i == IDX_WIDTH'(i)) begin
        rd_data_o = mem_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_row_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_row_feeder
//  Description : Buffers one N x N operand matrix loaded row by row, then on
//                start clears the skew crossbar, streams the rows with shift
//                asserted and flushes N zero rows so the deepest lane drains.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_row_feeder
  import matrix_feeder_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ARRAY_ELLEMENTS = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  load_valid,
  output logic                                  load_ready,
  input  logic [ARRAY_ELLEMENTS*DATA_WIDTH-1:0] load_data,
  input  logic                                  start,
  input  logic                                  stall,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  xbar_sync_reset_n,
  output logic                                  xbar_shift,
  output logic [ARRAY_ELLEMENTS*DATA_WIDTH-1:0] xbar_data
);

  localparam int c_cnt_w = cnt_width(ARRAY_ELLEMENTS);
  localparam int c_row_w = ARRAY_ELLEMENTS * DATA_WIDTH;
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(ARRAY_ELLEMENTS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  state_e               state_q, state_d;
  logic [c_cnt_w-1:0]   wr_cnt_q, wr_cnt_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sync_n_q, sync_n_d;
  logic                 shift_q, shift_d;
  logic [c_row_w-1:0]   data_q, data_d;

  logic                 w_wr_en;
  logic [c_cnt_w-1:0]   w_rd_idx;
  logic [c_row_w-1:0]   w_rd_data;

  assign load_ready = (state_q == IDLE);
  assign w_wr_en    = load_valid && load_ready;
  // The registered output always shows the row being entered, so the read
  // port looks one row ahead of the row currently on xbar_data.
  assign w_rd_idx   = (state_q == CLEAR) ? '0 : (cnt_q + c_cnt_one);

  row_buffer #(
    .ENTRIES   (ARRAY_ELLEMENTS),
    .ROW_WIDTH (c_row_w),
    .IDX_WIDTH (c_cnt_w)
  ) u_row_buffer (
    .clk       (clk),
    .wr_en_i   (w_wr_en),
    .wr_idx_i  (wr_cnt_q),
    .wr_data_i (load_data),
    .rd_idx_i  (w_rd_idx),
    .rd_data_o (w_rd_data)
  );

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sync_n_q <= 1'b1;
      shift_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sync_n_q <= sync_n_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
    end
  end

  // Next state plus the output values that accompany the state being entered.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sync_n_d = 1'b1;
    shift_d  = 1'b0;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (w_wr_en) begin
          wr_cnt_d = wr_cnt_q + c_cnt_one;
          if (wr_cnt_q == c_last) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        if (start) begin
          state_d  = CLEAR;
          sync_n_d = 1'b0;
          busy_d   = 1'b1;
          data_d   = '0;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
        data_d  = w_rd_data;
        shift_d = 1'b1;
        busy_d  = 1'b1;
      end
      STREAM: begin
        // A stall freezes counters and data; only shift drops.
        if (!stall) begin
          shift_d = 1'b1;
          if (cnt_q == c_last) begin
            state_d = FLUSH;
            cnt_d   = '0;
            data_d  = '0;
          end else begin
            cnt_d  = cnt_q + c_cnt_one;
            data_d = w_rd_data;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          if (cnt_q == c_last) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q + c_cnt_one;
            shift_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        wr_cnt_d = '0;
      end
      default: begin
        state_d  = IDLE;
        wr_cnt_d = '0;
        busy_d   = 1'b0;
        data_d   = '0;
      end
    endcase
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign xbar_sync_reset_n = sync_n_q;
  assign xbar_shift        = shift_q;
  assign xbar_data         = data_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_row_feeder
//  Description : Directed self-checking bench for matrix_row_feeder (N=4 and
//                N=1 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_row_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // N=4, DW=8 instance
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        busy, done, xbar_sync_reset_n, xbar_shift;
  logic [31:0] xbar_data;

  // N=1, DW=8 instance
  logic        load_valid1 = 1'b0;
  logic        load_ready1;
  logic [7:0]  load_data1 = '0;
  logic        start1 = 1'b0;
  logic        stall1 = 1'b0;
  logic        busy1, done1, sync_n1, shift1;
  logic [7:0]  xbar_data1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_rows [4];

  always #5 clk = ~clk;

  matrix_row_feeder #(.DATA_WIDTH(8), .ARRAY_ELLEMENTS(4)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .start(start), .stall(stall), .busy(busy), .done(done),
    .xbar_sync_reset_n(xbar_sync_reset_n), .xbar_shift(xbar_shift), .xbar_data(xbar_data)
  );

  matrix_row_feeder #(.DATA_WIDTH(8), .ARRAY_ELLEMENTS(1)) dut1 (
    .clk(clk), .reset(reset), .load_valid(load_valid1), .load_ready(load_ready1),
    .load_data(load_data1), .start(start1), .stall(stall1), .busy(busy1), .done(done1),
    .xbar_sync_reset_n(sync_n1), .xbar_shift(shift1), .xbar_data(xbar_data1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_matrix();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("ready_before_row%0d", k), load_ready, 1);
      load_valid = 1'b1;
      load_data  = exp_rows[k];
      tick();
    end
    load_valid = 1'b0;
    check("ready_after_load", load_ready, 0);
  endtask

  // Start in the current cycle and check every cycle until IDLE returns.
  task automatic do_stream(input int stall_row, input int stall_len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clear_sync_n", xbar_sync_reset_n, 0);
    check("clear_shift", xbar_shift, 0);
    check("clear_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("row%0d_data", k), xbar_data, exp_rows[k]);
      check($sformatf("row%0d_shift", k), xbar_shift, 1);
      check($sformatf("row%0d_sync_n", k), xbar_sync_reset_n, 1);
      if (k == stall_row) begin
        stall = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check($sformatf("stall%0d_data", s), xbar_data, exp_rows[k]);
          check($sformatf("stall%0d_shift", s), xbar_shift, 0);
          check($sformatf("stall%0d_done", s), done, 0);
        end
        stall = 1'b0;
      end
    end
    for (int z = 0; z < 4; z++) begin
      tick();
      check($sformatf("flush%0d_data", z), xbar_data, 0);
      check($sformatf("flush%0d_shift", z), xbar_shift, 1);
      check($sformatf("flush%0d_done", z), done, 0);
      check($sformatf("flush%0d_busy", z), busy, 1);
    end
    tick();
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_shift", xbar_shift, 0);
    tick();
    check("post_done", done, 0);
    check("post_ready", load_ready, 1);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", load_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_shift", xbar_shift, 0);
    check("rst_sync_n", xbar_sync_reset_n, 1);
    check("rst_data", xbar_data, 0);

    // Plain load and stream
    exp_rows[0] = 32'h04030201; exp_rows[1] = 32'h08070605;
    exp_rows[2] = 32'h0C0B0A09; exp_rows[3] = 32'h100F0E0D;
    load_matrix();
    do_stream(-1, 0);

    // Back-to-back reload with a 3-cycle stall on row 1
    exp_rows[0] = 32'h0A0B0C0D; exp_rows[1] = 32'h1A1B1C1D;
    exp_rows[2] = 32'h2A2B2C2D; exp_rows[3] = 32'h3A3B3C3D;
    load_matrix();
    do_stream(1, 3);

    // start ignored in IDLE (with and without a concurrent load)
    exp_rows[0] = 32'h11223344; exp_rows[1] = 32'h55667788;
    exp_rows[2] = 32'h99AABBCC; exp_rows[3] = 32'hDDEEFF00;
    load_valid = 1'b1; load_data = exp_rows[0]; tick();
    load_valid = 1'b1; load_data = exp_rows[1]; start = 1'b1; tick();
    load_valid = 1'b0; start = 1'b0;
    check("ld_start_busy", busy, 0);
    check("ld_start_ready", load_ready, 1);
    start = 1'b1; tick(); start = 1'b0;
    check("idle_start_busy", busy, 0);
    check("idle_start_sync_n", xbar_sync_reset_n, 1);
    check("idle_start_ready", load_ready, 1);
    load_valid = 1'b1; load_data = exp_rows[2]; tick();
    load_valid = 1'b1; load_data = exp_rows[3]; tick();
    // load in READY must not be accepted
    load_valid = 1'b1; load_data = 32'hDEADBEEF; tick();
    load_valid = 1'b0;
    check("ready_ignores_load", load_ready, 0);
    check("ready_busy", busy, 0);
    do_stream(-1, 0);

    // Reset mid-STREAM while row 2 is shown
    exp_rows[0] = 32'h04030201; exp_rows[1] = 32'h08070605;
    exp_rows[2] = 32'h0C0B0A09; exp_rows[3] = 32'h100F0E0D;
    load_matrix();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_row2", xbar_data, 32'h0C0B0A09);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_shift", xbar_shift, 0);
    check("mid_rst_data", xbar_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", load_ready, 1);
    check("mid_rst_sync_n", xbar_sync_reset_n, 1);
    exp_rows[0] = 32'hC0C1C2C3; exp_rows[1] = 32'hD0D1D2D3;
    exp_rows[2] = 32'hE0E1E2E3; exp_rows[3] = 32'hF0F1F2F3;
    load_matrix();
    do_stream(-1, 0);

    // N=1 instance
    check("n1_ready", load_ready1, 1);
    load_valid1 = 1'b1; load_data1 = 8'hAA; tick(); load_valid1 = 1'b0;
    check("n1_ready_after_load", load_ready1, 0);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check("n1_clear", sync_n1, 0);
    check("n1_clear_busy", busy1, 1);
    tick();
    check("n1_row_data", xbar_data1, 8'hAA);
    check("n1_row_shift", shift1, 1);
    tick();
    check("n1_flush_data", xbar_data1, 0);
    check("n1_flush_shift", shift1, 1);
    check("n1_flush_done", done1, 0);
    tick();
    check("n1_done", done1, 1);
    check("n1_done_busy", busy1, 0);
    tick();
    check("n1_post_ready", load_ready1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
